// File: rtl/tone_period_meter.sv
// Tone period meter: recovers the period of a square-wave tone in whole
// microseconds and flags the absence of a tone after a timeout window.
module tone_period_meter #(
  parameter int unsigned CLKS_PER_US = 100,
  parameter int unsigned TIMEOUT_US  = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tone_in,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        no_tone
);

  localparam int unsigned PRESC_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLKS_PER_US - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE   = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO  = '0;
  localparam logic [31:0]        CNT_LAST    = 32'(TIMEOUT_US - 1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                delay_q, delay_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [31:0]         per_cnt_q, per_cnt_d;
  logic [31:0]         period_q, period_d;
  logic                valid_q, valid_d;
  logic                no_tone_q, no_tone_d;
  logic                rise;
  logic                tick;

  // The rise cycle itself occupies prescaler slot 0, so counting resumes at
  // slot 1; this makes the reported value floor(rise spacing / CLKS_PER_US).
  always_comb begin
    sync1_d   = tone_in;
    sync2_d   = sync1_q;
    delay_d   = sync2_q;
    rise      = sync2_q & ~delay_q;
    tick      = (presc_q == PRESC_LAST);

    state_d   = state_q;
    presc_d   = presc_q;
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    no_tone_d = no_tone_q;

    case (state_q)
      IDLE: begin
        presc_d   = PRESC_ZERO;
        per_cnt_d = '0;
        if (rise) begin
          state_d = MEASURE;
          presc_d = PRESC_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d  = per_cnt_q;
          valid_d   = 1'b1;
          no_tone_d = 1'b0;
          presc_d   = PRESC_ONE;
          per_cnt_d = '0;
        end else if (tick && (per_cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          no_tone_d = 1'b1;
          period_d  = '0;
          presc_d   = PRESC_ZERO;
          per_cnt_d = '0;
        end else if (tick) begin
          presc_d   = PRESC_ZERO;
          per_cnt_d = per_cnt_q + 32'd1;
        end else begin
          presc_d   = presc_q + PRESC_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      delay_q   <= 1'b0;
      presc_q   <= PRESC_ZERO;
      per_cnt_q <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      no_tone_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      delay_q   <= delay_d;
      presc_q   <= presc_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      no_tone_q <= no_tone_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign no_tone      = no_tone_q;

endmodule
